pipeline_hazard_ctrl: RTL and testbench

Sequencing controller for the IF/ID pipeline register and the PC. It detects load-use hazards and taken branches resolved in ID, and drives the PC write enable, the IF/ID `stall`/`flush` inputs and the ID/EX bubble insert. It also runs the debug halt/single-step/resume state machine and keeps saturating hazard statistics counters that the debug unit reads back.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the IF/ID hazard and debug sequencing controller.
// The FSM encoding is fixed so the debug unit can decode dbg_state directly.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The front end advances only in RUN and STEP.
  function automatic logic state_is_active(state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Drives PC write, IF/ID stall/flush and ID/EX bubble from load-use and taken-branch
// hazards, runs the debug halt/step/resume FSM and keeps hazard statistics.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int         COUNT_W     = 16,
  parameter logic [5:0] HALT_OPCODE = hazard_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [5:0]         id_opcode,
  input  logic               id_branch_taken,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic               dbg_halt_req,
  input  logic               dbg_step_req,
  input  logic               dbg_resume_req,
  input  logic               dbg_clr_counts,
  output logic               pc_write,
  output logic               if_id_stall,
  output logic               if_id_flush,
  output logic               id_ex_bubble,
  output logic               halted,
  output logic               program_end,
  output logic               step_done,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count,
  output logic [1:0]         dbg_state
);

  // Debug commands are single-cycle pulses with no handshake: a command is
  // acted on at the edge where it is sampled high, or dropped if the current
  // state does not accept it.

  state_t state_q;
  state_t state_d;
  logic   step_done_q;
  logic   step_done_d;

  logic   lu;
  logic   br;
  logic   active;
  logic   is_halt_op;

  assign lu         = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  // A branch compare read stale operands when a load-use is pending, so it is ignored.
  assign br         = id_branch_taken && !lu;
  assign active     = state_is_active(state_q);
  assign is_halt_op = (id_opcode == HALT_OPCODE);

  always_comb begin
    pc_write     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    step_done_d  = 1'b0;

    if (active) begin
      if (lu) begin
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (br) begin
        pc_write    = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
    end else begin
      // Frozen front end; the back end drains behind bubbles.
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (is_halt_op && !lu) begin
          state_d = ST_DONE;
        end else if (dbg_halt_req) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (dbg_resume_req) begin
          state_d = ST_RUN;
        end else if (dbg_step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (!lu) begin
          step_done_d = 1'b1;
          state_d     = is_halt_op ? ST_DONE : ST_HALTED;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_done_q <= step_done_d;
    end
  end

  sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active && lu),
    .clr   (dbg_clr_counts),
    .count (stall_count)
  );

  // Counts flushes actually issued, so branches seen while frozen are not counted.
  sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (active && br),
    .clr   (dbg_clr_counts),
    .count (flush_count)
  );

  assign halted      = (state_q == ST_HALTED) || (state_q == ST_DONE);
  assign program_end = (state_q == ST_DONE);
  assign step_done   = step_done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the controller.
module tb_pipeline_hazard_ctrl;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int M_RUN    = 0;
  localparam int M_HALTED = 1;
  localparam int M_STEP   = 2;
  localparam int M_DONE   = 3;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic [5:0]    id_opcode;
  logic          id_branch_taken, ex_mem_read;
  logic          dbg_halt_req, dbg_step_req, dbg_resume_req, dbg_clr_counts;
  logic          pc_write, if_id_stall, if_id_flush, id_ex_bubble;
  logic          halted, program_end, step_done;
  logic [CW-1:0] stall_count, flush_count;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_errors;

  // behavioural model state
  int m_state;
  int m_stall;
  int m_flush;
  bit m_step_done;

  pipeline_hazard_ctrl #(.COUNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_opcode       (id_opcode),
    .id_branch_taken (id_branch_taken),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .dbg_halt_req    (dbg_halt_req),
    .dbg_step_req    (dbg_step_req),
    .dbg_resume_req  (dbg_resume_req),
    .dbg_clr_counts  (dbg_clr_counts),
    .pc_write        (pc_write),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .halted          (halted),
    .program_end     (program_end),
    .step_done       (step_done),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_opcode = 6'd0;
    id_branch_taken = 1'b0; ex_mem_read = 1'b0;
    dbg_halt_req = 1'b0; dbg_step_req = 1'b0; dbg_resume_req = 1'b0; dbg_clr_counts = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rt_ex, input logic [4:0] rs_id);
    ex_mem_read = 1'b1; ex_rt = rt_ex; id_rs = rs_id; id_rt = 5'd31;
  endtask

  function automatic bit model_lu();
    return ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  // scoreboard: compare every visible output with the model's view of this cycle
  task automatic check_now(input string tag);
    bit lu, br, act, pc, st, fl, bub;
    logic [6:0] exp_v, obs_v;
    lu  = model_lu();
    br  = id_branch_taken && !lu;
    act = (m_state == M_RUN) || (m_state == M_STEP);
    pc = 0; st = 0; fl = 0; bub = 0;
    if (!act || lu) begin
      st = 1; bub = 1;
    end else begin
      pc = 1; fl = br;
    end
    exp_v = {pc, st, fl, bub, (m_state == M_HALTED) || (m_state == M_DONE),
             m_state == M_DONE, m_step_done};
    obs_v = {pc_write, if_id_stall, if_id_flush, id_ex_bubble, halted, program_end, step_done};
    check({tag, "/ctrl"}, 32'(obs_v), 32'(exp_v));
    check({tag, "/stall_cnt"}, 32'(stall_count), 32'(m_stall));
    check({tag, "/flush_cnt"}, 32'(flush_count), 32'(m_flush));
    check({tag, "/state"}, 32'(dbg_state), 32'(m_state));
  endtask

  // Called just after a rising edge with inputs already driven; checks, advances the model, clocks.
  task automatic cycle(input string tag);
    bit lu, act, halt_op;
    #3;
    check_now(tag);
    lu      = model_lu();
    act     = (m_state == M_RUN) || (m_state == M_STEP);
    halt_op = (id_opcode == 6'b111111);
    if (dbg_clr_counts) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (act && lu && m_stall < CNT_MAX) m_stall++;
      if (act && !lu && id_branch_taken && m_flush < CNT_MAX) m_flush++;
    end
    m_step_done = (m_state == M_STEP) && !lu;
    case (m_state)
      M_RUN:    if (halt_op && !lu) m_state = M_DONE;
                else if (dbg_halt_req) m_state = M_HALTED;
      M_HALTED: if (dbg_resume_req) m_state = M_RUN;
                else if (dbg_step_req) m_state = M_STEP;
      M_STEP:   if (!lu) m_state = halt_op ? M_DONE : M_HALTED;
      default:  m_state = M_DONE;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied mid-cycle, checked before and after the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    m_state = M_RUN; m_stall = 0; m_flush = 0; m_step_done = 0;
    #1;
    check_now({tag, "/async"});
    @(posedge clk);
    #1;
    check_now({tag, "/held"});
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    set_idle();
    reset = 1'b1;
    #2;
    do_reset("reset0");

    // load-use stalls, but not against r0
    set_idle(); set_load(5'd5, 5'd5);       cycle("lu");
    set_idle();                             cycle("lu_after");
    check("lu/stall_count", 32'(stall_count), 32'd1);
    set_idle(); set_load(5'd0, 5'd0);       cycle("lu_r0");

    // load-use beats a taken branch; branch alone flushes next
    set_idle(); set_load(5'd7, 5'd7); id_branch_taken = 1'b1; cycle("lu_br");
    set_idle(); id_branch_taken = 1'b1;     cycle("br");
    set_idle();                             cycle("br_after");
    check("br/flush_count", 32'(flush_count), 32'd1);

    // halt, then step held off by two load-use cycles
    set_idle(); dbg_halt_req = 1'b1;        cycle("halt_req");
    check("halt/halted", 32'(halted), 32'd1);
    set_idle(); dbg_step_req = 1'b1;        cycle("step_req");
    set_idle(); set_load(5'd3, 5'd3);       cycle("step_lu1");
    set_idle(); set_load(5'd3, 5'd3);       cycle("step_lu2");
    check("step/held", 32'(dbg_state), 32'(M_STEP));
    set_idle();                             cycle("step_go");
    check("step/done_pulse", 32'(step_done), 32'd1);
    set_idle();                             cycle("step_post");
    check("step/done_once", 32'(step_done), 32'd0);

    // resume beats step
    set_idle(); dbg_resume_req = 1'b1; dbg_step_req = 1'b1; cycle("resume_step");
    check("resume/state", 32'(dbg_state), 32'(M_RUN));
    set_idle();                             cycle("resume_after");

    // stall counter saturation, then clear beats increment
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      set_idle(); set_load(5'd9, 5'd9);     cycle("sat");
    end
    check("sat/max", 32'(stall_count), 32'(CNT_MAX));
    set_idle(); set_load(5'd9, 5'd9); dbg_clr_counts = 1'b1; cycle("clr_lu");
    check("clr/zero", 32'(stall_count), 32'd0);

    // reset while a step is about to complete: no stale step_done
    set_idle(); dbg_halt_req = 1'b1;        cycle("h2");
    set_idle(); dbg_step_req = 1'b1;        cycle("s2");
    set_idle();
    do_reset("reset_step");
    set_idle();                             cycle("post_reset_step");

    // halt opcode ends the program; debug commands are ignored
    set_idle(); id_opcode = 6'b111111;      cycle("halt_op");
    set_idle(); dbg_resume_req = 1'b1;      cycle("done_resume");
    set_idle(); dbg_step_req = 1'b1;        cycle("done_step");
    check("done/program_end", 32'(program_end), 32'd1);
    do_reset("reset_done");
    set_idle();                             cycle("post_reset_done");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_opcode       = ($urandom_range(0, 40) == 0) ? 6'b111111 : 6'($urandom_range(0, 62));
      dbg_halt_req    = ($urandom_range(0, 12) == 0);
      dbg_step_req    = ($urandom_range(0, 3) == 0);
      dbg_resume_req  = ($urandom_range(0, 8) == 0);
      dbg_clr_counts  = ($urandom_range(0, 60) == 0);
      if ((m_state == M_DONE && $urandom_range(0, 7) == 0) || $urandom_range(0, 300) == 0) begin
        do_reset("rnd_reset");
      end else begin
        cycle("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
